// File: rtl/slot_io_responder_if.sv
//------------------------------------------------------------------------------
// slot_io_responder_if
// Dock-to-slot I/O bus bundle (select, direction, address, data, wait).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface slot_io_responder_if #(
    parameter int REG_AW = 4,
    parameter int DATA_W = 8
);
    logic              cs_n;
    logic              r_w_;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic              dev_ready_n;

    modport master (
        output cs_n,
        output r_w_,
        output addr,
        output data_in,
        input  data_out,
        input  data_oe,
        input  dev_ready_n
    );

    modport slave (
        input  cs_n,
        input  r_w_,
        input  addr,
        input  data_in,
        output data_out,
        output data_oe,
        output dev_ready_n
    );
endinterface

`default_nettype wire

// File: rtl/slot_io_responder.sv
//------------------------------------------------------------------------------
// slot_io_responder
// Turns dock I/O cycles into single req/ack local register transactions,
// stretching the bus cycle with dev_ready_n until ack, minimum wait or timeout.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module slot_io_responder #(
    parameter int REG_AW   = 4,
    parameter int DATA_W   = 8,
    parameter int MIN_WAIT = 0,
    parameter int TIMEOUT  = 255
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    slot_io_responder_if.slave     bus,
    output logic                   loc_req,
    output logic                   loc_we,
    output logic [REG_AW-1:0]      loc_addr,
    output logic [DATA_W-1:0]      loc_wdata,
    input  wire logic [DATA_W-1:0] loc_rdata,
    input  wire logic              loc_ack,
    output logic                   timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_MIN_WAIT = CNT_W'(MIN_WAIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_acked;
    logic              r_loc_req;
    logic              r_loc_we;
    logic [REG_AW-1:0] r_loc_addr;
    logic [DATA_W-1:0] r_loc_wdata;
    logic [DATA_W-1:0] r_data_out;
    logic              r_timeout_err;

    logic              w_min_met;
    logic              w_done;
    logic              w_is_read;

    // A zero minimum wait makes the count comparison vacuous; skip it entirely.
    generate
        if (MIN_WAIT == 0) begin : g_no_min_wait
            assign w_min_met = 1'b1;
        end else begin : g_min_wait
            assign w_min_met = (r_cnt >= c_MIN_WAIT);
        end
    endgenerate

    assign w_done    = (r_acked | loc_ack) & w_min_met;
    assign w_is_read = ~r_loc_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_acked       <= 1'b0;
            r_loc_req     <= 1'b0;
            r_loc_we      <= 1'b0;
            r_loc_addr    <= '0;
            r_loc_wdata   <= '0;
            r_data_out    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!bus.cs_n) begin
                        r_state     <= S_ACCESS;
                        r_loc_addr  <= bus.addr;
                        r_loc_we    <= ~bus.r_w_;
                        r_loc_wdata <= bus.data_in;
                        r_loc_req   <= 1'b1;
                        r_cnt       <= '0;
                        r_acked     <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    if (bus.cs_n) begin
                        r_loc_req <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (w_done) begin
                        r_state   <= S_HOLD;
                        r_loc_req <= 1'b0;
                        if (loc_ack && w_is_read) begin
                            r_data_out <= loc_rdata;
                        end
                    end else if (loc_ack) begin
                        // Early ack: capture now, keep stretching until the minimum wait is met.
                        r_acked   <= 1'b1;
                        r_loc_req <= 1'b0;
                        if (w_is_read) begin
                            r_data_out <= loc_rdata;
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end else if ((r_cnt == c_TIMEOUT) && !r_acked) begin
                        r_state       <= S_HOLD;
                        r_loc_req     <= 1'b0;
                        r_timeout_err <= 1'b1;
                        if (w_is_read) begin
                            r_data_out <= '1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.cs_n) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Wait asserts combinationally on select so the dock never sees a false ready.
    assign bus.dev_ready_n = ~(rst_n & (((r_state == S_IDLE) & ~bus.cs_n) | (r_state == S_ACCESS)));
    assign bus.data_oe     = rst_n & (r_state == S_HOLD) & w_is_read & ~bus.cs_n;
    assign bus.data_out    = r_data_out;

    assign loc_req     = r_loc_req;
    assign loc_we      = r_loc_we;
    assign loc_addr    = r_loc_addr;
    assign loc_wdata   = r_loc_wdata;
    assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_slot_io_responder.sv
//------------------------------------------------------------------------------
// tb_slot_io_responder
// Directed bench: unit A (MIN_WAIT=0, TIMEOUT=4), unit B (MIN_WAIT=3, TIMEOUT=8).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_slot_io_responder;

    logic       clk;
    logic       rst_n;
    logic       cs_n;
    logic       r_w_;
    logic [3:0] addr;
    logic [7:0] data_in;
    logic [7:0] loc_rdata;
    logic       loc_ack;

    int n_cmp;
    int n_fail;

    slot_io_responder_if #(.REG_AW(4), .DATA_W(8)) ifa ();
    slot_io_responder_if #(.REG_AW(4), .DATA_W(8)) ifb ();

    assign ifa.cs_n = cs_n;  assign ifa.r_w_ = r_w_;  assign ifa.addr = addr;  assign ifa.data_in = data_in;
    assign ifb.cs_n = cs_n;  assign ifb.r_w_ = r_w_;  assign ifb.addr = addr;  assign ifb.data_in = data_in;

    logic       a_req, a_we, a_terr, b_req, b_we, b_terr;
    logic [3:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;

    slot_io_responder #(.REG_AW(4), .DATA_W(8), .MIN_WAIT(0), .TIMEOUT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa),
        .loc_req(a_req), .loc_we(a_we), .loc_addr(a_addr), .loc_wdata(a_wdata),
        .loc_rdata(loc_rdata), .loc_ack(loc_ack), .timeout_err(a_terr)
    );

    slot_io_responder #(.REG_AW(4), .DATA_W(8), .MIN_WAIT(3), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb),
        .loc_req(b_req), .loc_we(b_we), .loc_addr(b_addr), .loc_wdata(b_wdata),
        .loc_rdata(loc_rdata), .loc_ack(loc_ack), .timeout_err(b_terr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        cs_n = 1'b1; r_w_ = 1'b1; addr = 4'h0; data_in = 8'h00; loc_ack = 1'b0; loc_rdata = 8'h00;
        step(); step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_idle();
        n_cmp++; if (a_req !== 1'b0)          begin n_fail++; $display("FAIL rst_req got %b want 0", a_req); end
        n_cmp++; if (a_we !== 1'b0)           begin n_fail++; $display("FAIL rst_we got %b want 0", a_we); end
        n_cmp++; if (a_addr !== 4'h0)         begin n_fail++; $display("FAIL rst_addr got %h want 0", a_addr); end
        n_cmp++; if (a_wdata !== 8'h00)       begin n_fail++; $display("FAIL rst_wdata got %h want 00", a_wdata); end
        n_cmp++; if (ifa.data_out !== 8'h00)  begin n_fail++; $display("FAIL rst_dout got %h want 00", ifa.data_out); end
        n_cmp++; if (ifa.dev_ready_n !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", ifa.dev_ready_n); end
        n_cmp++; if (ifa.data_oe !== 1'b0)    begin n_fail++; $display("FAIL rst_oe got %b want 0", ifa.data_oe); end
        n_cmp++; if (a_terr !== 1'b0)         begin n_fail++; $display("FAIL rst_terr got %b want 0", a_terr); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write();
        cs_n = 1'b0; r_w_ = 1'b0; addr = 4'h3; data_in = 8'hA5;
        #1;
        n_cmp++; if (ifa.dev_ready_n !== 1'b0) begin n_fail++; $display("FAIL wr_zero_lat_wait got %b want 0", ifa.dev_ready_n); end
        step();
        n_cmp++; if (a_req !== 1'b1)   begin n_fail++; $display("FAIL wr_req got %b want 1", a_req); end
        n_cmp++; if (a_addr !== 4'h3)  begin n_fail++; $display("FAIL wr_addr got %h want 3", a_addr); end
        n_cmp++; if (a_we !== 1'b1)    begin n_fail++; $display("FAIL wr_we got %b want 1", a_we); end
        n_cmp++; if (a_wdata !== 8'hA5) begin n_fail++; $display("FAIL wr_wdata got %h want a5", a_wdata); end
        data_in = 8'h00;
        step();
        n_cmp++; if (ifa.dev_ready_n !== 1'b0) begin n_fail++; $display("FAIL wr_wait1 got %b want 0", ifa.dev_ready_n); end
        loc_ack = 1'b1;
        step();
        loc_ack = 1'b0;
        #1;
        n_cmp++; if (ifa.dev_ready_n !== 1'b1) begin n_fail++; $display("FAIL wr_release got %b want 1", ifa.dev_ready_n); end
        n_cmp++; if (a_req !== 1'b0)           begin n_fail++; $display("FAIL wr_req_drop got %b want 0", a_req); end
        n_cmp++; if (ifa.data_oe !== 1'b0)     begin n_fail++; $display("FAIL wr_oe got %b want 0", ifa.data_oe); end
        cs_n = 1'b1;
        step();
        // Probe for IDLE: a fresh select must assert wait immediately.
        cs_n = 1'b0;
        #1;
        n_cmp++; if (ifa.dev_ready_n !== 1'b0) begin n_fail++; $display("FAIL wr_back_idle got %b want 0", ifa.dev_ready_n); end
        cs_n = 1'b1;
        bus_idle();
    endtask

    task automatic test_read();
        cs_n = 1'b0; r_w_ = 1'b1; addr = 4'h7;
        step();
        n_cmp++; if (a_we !== 1'b0) begin n_fail++; $display("FAIL rd_we got %b want 0", a_we); end
        loc_ack = 1'b1; loc_rdata = 8'h5C;
        step();
        loc_ack = 1'b0; loc_rdata = 8'h00;
        #1;
        n_cmp++; if (ifa.data_out !== 8'h5C)   begin n_fail++; $display("FAIL rd_data got %h want 5c", ifa.data_out); end
        n_cmp++; if (ifa.data_oe !== 1'b1)     begin n_fail++; $display("FAIL rd_oe got %b want 1", ifa.data_oe); end
        n_cmp++; if (ifa.dev_ready_n !== 1'b1) begin n_fail++; $display("FAIL rd_release got %b want 1", ifa.dev_ready_n); end
        step();
        n_cmp++; if (ifa.data_out !== 8'h5C) begin n_fail++; $display("FAIL rd_hold_data got %h want 5c", ifa.data_out); end
        cs_n = 1'b1;
        #1;
        n_cmp++; if (ifa.data_oe !== 1'b0) begin n_fail++; $display("FAIL rd_oe_off got %b want 0", ifa.data_oe); end
        bus_idle();
    endtask

    task automatic test_min_wait();
        cs_n = 1'b0; r_w_ = 1'b1; addr = 4'h2;
        step();
        loc_ack = 1'b1; loc_rdata = 8'h3C;
        step();
        loc_ack = 1'b0; loc_rdata = 8'h00;
        #1;
        n_cmp++; if (b_req !== 1'b0)           begin n_fail++; $display("FAIL mw_req_drop got %b want 0", b_req); end
        n_cmp++; if (ifb.dev_ready_n !== 1'b0) begin n_fail++; $display("FAIL mw_wait_e1 got %b want 0", ifb.dev_ready_n); end
        step();
        n_cmp++; if (ifb.dev_ready_n !== 1'b0) begin n_fail++; $display("FAIL mw_wait_e2 got %b want 0", ifb.dev_ready_n); end
        step();
        n_cmp++; if (ifb.dev_ready_n !== 1'b0) begin n_fail++; $display("FAIL mw_wait_e3 got %b want 0", ifb.dev_ready_n); end
        step();
        n_cmp++; if (ifb.dev_ready_n !== 1'b1) begin n_fail++; $display("FAIL mw_release got %b want 1", ifb.dev_ready_n); end
        n_cmp++; if (ifb.data_out !== 8'h3C)   begin n_fail++; $display("FAIL mw_data got %h want 3c", ifb.data_out); end
        n_cmp++; if (ifb.data_oe !== 1'b1)     begin n_fail++; $display("FAIL mw_oe got %b want 1", ifb.data_oe); end
        n_cmp++; if (b_terr !== 1'b0)          begin n_fail++; $display("FAIL mw_terr got %b want 0", b_terr); end
        bus_idle();
    endtask

    task automatic test_timeout();
        cs_n = 1'b0; r_w_ = 1'b1; addr = 4'h1;
        step();
        for (int k = 1; k <= 4; k++) begin
            step();
            n_cmp++; if (ifa.dev_ready_n !== 1'b0) begin n_fail++; $display("FAIL to_wait_e%0d got %b want 0", k, ifa.dev_ready_n); end
            n_cmp++; if (a_terr !== 1'b0)          begin n_fail++; $display("FAIL to_early_e%0d got %b want 0", k, a_terr); end
        end
        step();
        n_cmp++; if (a_terr !== 1'b1)          begin n_fail++; $display("FAIL to_pulse got %b want 1", a_terr); end
        n_cmp++; if (ifa.data_out !== 8'hFF)   begin n_fail++; $display("FAIL to_data got %h want ff", ifa.data_out); end
        n_cmp++; if (ifa.dev_ready_n !== 1'b1) begin n_fail++; $display("FAIL to_release got %b want 1", ifa.dev_ready_n); end
        n_cmp++; if (a_req !== 1'b0)           begin n_fail++; $display("FAIL to_req got %b want 0", a_req); end
        step();
        n_cmp++; if (a_terr !== 1'b0) begin n_fail++; $display("FAIL to_one_shot got %b want 0", a_terr); end
        bus_idle();
    endtask

    task automatic test_abandon();
        cs_n = 1'b0; r_w_ = 1'b1; addr = 4'h5;
        step();
        step();
        cs_n = 1'b1;
        step();
        n_cmp++; if (a_req !== 1'b0)           begin n_fail++; $display("FAIL ab_req got %b want 0", a_req); end
        n_cmp++; if (ifa.dev_ready_n !== 1'b1) begin n_fail++; $display("FAIL ab_ready got %b want 1", ifa.dev_ready_n); end
        loc_ack = 1'b1; loc_rdata = 8'h99;
        step();
        loc_ack = 1'b0; loc_rdata = 8'h00;
        #1;
        n_cmp++; if (ifa.data_out !== 8'hFF) begin n_fail++; $display("FAIL ab_late_ack got %h want ff", ifa.data_out); end
        cs_n = 1'b0; r_w_ = 1'b0; addr = 4'h9; data_in = 8'h42;
        step();
        n_cmp++; if (a_addr !== 4'h9)  begin n_fail++; $display("FAIL ab_next_addr got %h want 9", a_addr); end
        n_cmp++; if (a_req !== 1'b1)   begin n_fail++; $display("FAIL ab_next_req got %b want 1", a_req); end
        n_cmp++; if (a_wdata !== 8'h42) begin n_fail++; $display("FAIL ab_next_wdata got %h want 42", a_wdata); end
        bus_idle();
    endtask

    task automatic test_reset_mid();
        cs_n = 1'b0; r_w_ = 1'b0; addr = 4'hE; data_in = 8'h77;
        step();
        n_cmp++; if (a_req !== 1'b1) begin n_fail++; $display("FAIL rm_req_pre got %b want 1", a_req); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (a_req !== 1'b0)           begin n_fail++; $display("FAIL rm_req got %b want 0", a_req); end
        n_cmp++; if (ifa.dev_ready_n !== 1'b1) begin n_fail++; $display("FAIL rm_ready got %b want 1", ifa.dev_ready_n); end
        n_cmp++; if (ifa.data_oe !== 1'b0)     begin n_fail++; $display("FAIL rm_oe got %b want 0", ifa.data_oe); end
        n_cmp++; if (a_addr !== 4'h0)          begin n_fail++; $display("FAIL rm_addr got %h want 0", a_addr); end
        n_cmp++; if (a_we !== 1'b0)            begin n_fail++; $display("FAIL rm_we got %b want 0", a_we); end
        n_cmp++; if (ifa.data_out !== 8'h00)   begin n_fail++; $display("FAIL rm_dout got %h want 00", ifa.data_out); end
        n_cmp++; if (b_req !== 1'b0)           begin n_fail++; $display("FAIL rm_b_req got %b want 0", b_req); end
        cs_n = 1'b1;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        cs_n = 1'b1; r_w_ = 1'b1; addr = 4'h0; data_in = 8'h00; loc_ack = 1'b0; loc_rdata = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_min_wait();
        test_timeout();
        test_abandon();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
